// File: rtl/regfile_ctrl.sv
// regfile_ctrl: clears the Y86 register file after reset. It sequences dual
// writebacks (dstE, then dstM) through the single write port. It also
// arbitrates that port and the spare read port between the core and a
// debug/host requester, with a starvation guard for the debug side.
module regfile_ctrl #(
  parameter int NREG       = 15,
  parameter int DW         = 64,
  parameter int AW         = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wb_valid_i,
  input  logic [AW-1:0] dstE_i,
  input  logic [DW-1:0] valE_i,
  input  logic [AW-1:0] dstM_i,
  input  logic [DW-1:0] valM_i,
  output logic          wb_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_ack_o,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o,
  output logic [AW-1:0] rf_raddr_o,
  input  logic [DW-1:0] rf_rdata_i,
  output logic          init_done_o
);

  localparam int CW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] REG_NONE = {AW{1'b1}};

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_IDLE    = 2'd1,
    S_WB_M    = 2'd2,
    S_DBG_ACK = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [AW-1:0] dstm_q, dstm_d;
  logic [DW-1:0] valm_q, valm_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          init_done_q, init_done_d;

  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [DW-1:0] wdata_s;
  logic          stall_s;
  logic          grant_s;
  logic          starved_s;
  logic [SW-1:0] starve_inc_s;
  logic          core_dual_s;
  logic [AW-1:0] core_waddr_s;
  logic [DW-1:0] core_wdata_s;

  // Core writeback decode: dual when both destinations are real, else pick the real one.
  always_comb begin
    core_dual_s  = (dstE_i != REG_NONE) && (dstM_i != REG_NONE);
    core_waddr_s = dstM_i;
    core_wdata_s = valM_i;
    if (dstE_i != REG_NONE) begin
      core_waddr_s = dstE_i;
      core_wdata_s = valE_i;
    end else begin
      core_waddr_s = dstM_i;
      core_wdata_s = valM_i;
    end
  end

  // Debug arbitration: debug wins when the core is idle or has starved it long enough.
  always_comb begin
    starved_s    = (starve_q == SW'(STARVE_MAX));
    starve_inc_s = starved_s ? starve_q : (starve_q + SW'(1));
    grant_s      = dbg_req_i && (!wb_valid_i || starved_s);
  end

  // Next-state and write-port control for the controller FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    dstm_d      = dstm_q;
    valm_d      = valm_q;
    rdata_d     = rdata_q;
    init_done_d = init_done_q;
    we_s        = 1'b0;
    waddr_s     = {AW{1'b0}};
    wdata_s     = {DW{1'b0}};
    stall_s     = 1'b0;

    case (state_q)
      S_INIT: begin
        we_s    = 1'b1;
        waddr_s = AW'(cnt_q);
        stall_s = 1'b1;
        if (cnt_q == CW'(NREG - 1)) begin
          cnt_d       = {CW{1'b0}};
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_IDLE: begin
        if (grant_s) begin
          // A preempted core holds its inputs; they are replayed later.
          stall_s  = wb_valid_i;
          starve_d = {SW{1'b0}};
          state_d  = S_DBG_ACK;
          if (dbg_we_i) begin
            we_s    = 1'b1;
            waddr_s = dbg_addr_i;
            wdata_s = dbg_wdata_i;
            rdata_d = {DW{1'b0}};
          end else begin
            rdata_d = (dbg_addr_i == REG_NONE) ? {DW{1'b0}} : rf_rdata_i;
          end
        end else begin
          if (dbg_req_i) begin
            starve_d = starve_inc_s;
          end else begin
            starve_d = {SW{1'b0}};
          end
          if (wb_valid_i) begin
            we_s    = 1'b1;
            waddr_s = core_waddr_s;
            wdata_s = core_wdata_s;
            stall_s = core_dual_s;
            if (core_dual_s) begin
              dstm_d  = dstM_i;
              valm_d  = valM_i;
              state_d = S_WB_M;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_WB_M: begin
        // Second half of a dual writeback; M is written last so it wins on dstE == dstM.
        we_s    = 1'b1;
        waddr_s = dstm_q;
        wdata_s = valm_q;
        state_d = S_IDLE;
      end

      S_DBG_ACK: begin
        if (dbg_req_i) begin
          starve_d = starve_q;
        end else begin
          starve_d = {SW{1'b0}};
        end
        if (wb_valid_i) begin
          we_s    = 1'b1;
          waddr_s = core_waddr_s;
          wdata_s = core_wdata_s;
          stall_s = core_dual_s;
          if (core_dual_s) begin
            dstm_d  = dstM_i;
            valm_d  = valM_i;
            state_d = S_WB_M;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_INIT;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and datapath registers; reset restarts the clearing sequence.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_INIT;
      cnt_q       <= {CW{1'b0}};
      starve_q    <= {SW{1'b0}};
      dstm_q      <= {AW{1'b0}};
      valm_q      <= {DW{1'b0}};
      rdata_q     <= {DW{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      dstm_q      <= dstm_d;
      valm_q      <= valm_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
    end
  end

  // Outputs are forced to their quiet values while reset is asserted.
  // Writes to the "none" index are dropped here.
  assign rf_we_o     = rst_n_i & we_s & (waddr_s != REG_NONE);
  assign rf_waddr_o  = rst_n_i ? waddr_s : {AW{1'b0}};
  assign rf_wdata_o  = rst_n_i ? wdata_s : {DW{1'b0}};
  assign wb_stall_o  = (~rst_n_i) | stall_s;
  assign dbg_ack_o   = rst_n_i & (state_q == S_DBG_ACK);
  assign dbg_rdata_o = dbg_ack_o ? rdata_q : {DW{1'b0}};
  assign rf_raddr_o  = dbg_addr_i;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed table-driven bench for regfile_ctrl with a
// behavioural register file hanging off the write/read ports.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [3:0]  dstE, dstM, dbg_addr, rf_waddr, rf_raddr;
  logic [63:0] valE, valM, dbg_wdata, dbg_rdata, rf_wdata, rf_rdata;
  logic        wb_stall, dbg_req, dbg_we, dbg_ack, rf_we, init_done;

  logic [63:0] rf_mem [0:15];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wbv;
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
    logic        req;
    logic        dwe;
    logic [3:0]  da;
    logic [63:0] dd;
    logic        xwe;
    logic [3:0]  xaddr;
    logic [63:0] xdata;
    logic        xstall;
    logic        xack;
    logic        xchk;
    logic [63:0] xrd;
  } vec_t;

  vec_t tbl [17];

  regfile_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_valid_i(wb_valid), .dstE_i(dstE), .valE_i(valE), .dstM_i(dstM), .valM_i(valM),
    .wb_stall_o(wb_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
    .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  // Register file model; index F returns a poison pattern the controller must mask.
  always @(posedge clk) begin
    if (rf_we && rf_waddr != 4'hF) rf_mem[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata = (rf_raddr == 4'hF) ? 64'hBAD0_BAD0_BAD0_BAD0 : rf_mem[rf_raddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic wbv, input logic [3:0] de, input logic [63:0] ve,
    input logic [3:0] dm, input logic [63:0] vm,
    input logic req, input logic dwe, input logic [3:0] da, input logic [63:0] dd,
    input logic xwe, input logic [3:0] xa, input logic [63:0] xd,
    input logic xs, input logic xk, input logic xc, input logic [63:0] xr);
    vec_t v;
    v.wbv = wbv; v.de = de; v.ve = ve; v.dm = dm; v.vm = vm;
    v.req = req; v.dwe = dwe; v.da = da; v.dd = dd;
    v.xwe = xwe; v.xaddr = xa; v.xdata = xd; v.xstall = xs; v.xack = xk;
    v.xchk = xc; v.xrd = xr;
    return v;
  endfunction

  task automatic idle_inputs();
    wb_valid = 1'b0; dstE = 4'hF; valE = 64'h0; dstM = 4'hF; valM = 64'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 4'h0; dbg_wdata = 64'h0;
  endtask

  // One cycle: drive after the active edge, compare on the falling edge.
  task automatic cyc(input vec_t v, input string tag);
    wb_valid = v.wbv; dstE = v.de; valE = v.ve; dstM = v.dm; valM = v.vm;
    dbg_req = v.req; dbg_we = v.dwe; dbg_addr = v.da; dbg_wdata = v.dd;
    @(negedge clk);
    chk({tag, "_we"}, 64'(rf_we), 64'(v.xwe));
    if (v.xwe) begin
      chk({tag, "_waddr"}, 64'(rf_waddr), 64'(v.xaddr));
      chk({tag, "_wdata"}, rf_wdata, v.xdata);
    end
    chk({tag, "_stall"}, 64'(wb_stall), 64'(v.xstall));
    chk({tag, "_ack"}, 64'(dbg_ack), 64'(v.xack));
    if (v.xchk) chk({tag, "_rdata"}, dbg_rdata, v.xrd);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, 64'(rf_we), 64'h0);
    chk({tag, "_waddr"}, 64'(rf_waddr), 64'h0);
    chk({tag, "_wdata"}, rf_wdata, 64'h0);
    chk({tag, "_stall"}, 64'(wb_stall), 64'h1);
    chk({tag, "_ack"}, 64'(dbg_ack), 64'h0);
    chk({tag, "_rdata"}, dbg_rdata, 64'h0);
    chk({tag, "_done"}, 64'(init_done), 64'h0);
  endtask

  // Called just after reset release: 15 clearing cycles, then done on cycle 16.
  task automatic init_sequence(input string tag);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("%s_init%0d_we", tag, i), 64'(rf_we), 64'h1);
      chk($sformatf("%s_init%0d_addr", tag, i), 64'(rf_waddr), 64'(i));
      chk($sformatf("%s_init%0d_data", tag, i), rf_wdata, 64'h0);
      chk($sformatf("%s_init%0d_stall", tag, i), 64'(wb_stall), 64'h1);
      chk($sformatf("%s_init%0d_done", tag, i), 64'(init_done), 64'h0);
      chk($sformatf("%s_init%0d_ack", tag, i), 64'(dbg_ack), 64'h0);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    chk({tag, "_done16"}, 64'(init_done), 64'h1);
    chk({tag, "_stall16"}, 64'(wb_stall), 64'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t s;
    // wbv de ve dm vm | req dwe da dd | xwe xaddr xdata xstall xack xchk xrd
    tbl[0]  = mk(1, 4'h3, 64'h1234, 4'hF, 64'h0,    0, 0, 4'h0, 64'h0,    1, 4'h3, 64'h1234, 0, 0, 0, 64'h0);
    tbl[1]  = mk(1, 4'hF, 64'h0,    4'h6, 64'h66,   0, 0, 4'h0, 64'h0,    1, 4'h6, 64'h66,   0, 0, 0, 64'h0);
    tbl[2]  = mk(0, 4'hF, 64'h0,    4'hF, 64'h0,    0, 0, 4'h0, 64'h0,    0, 4'h0, 64'h0,    0, 0, 0, 64'h0);
    tbl[3]  = mk(1, 4'h4, 64'h108,  4'h2, 64'hABCD, 0, 0, 4'h0, 64'h0,    1, 4'h4, 64'h108,  1, 0, 0, 64'h0);
    tbl[4]  = mk(1, 4'h4, 64'h108,  4'h2, 64'hABCD, 0, 0, 4'h0, 64'h0,    1, 4'h2, 64'hABCD, 0, 0, 0, 64'h0);
    tbl[5]  = mk(1, 4'h4, 64'h110,  4'h4, 64'hABCD, 0, 0, 4'h0, 64'h0,    1, 4'h4, 64'h110,  1, 0, 0, 64'h0);
    tbl[6]  = mk(1, 4'h4, 64'h110,  4'h4, 64'hABCD, 0, 0, 4'h0, 64'h0,    1, 4'h4, 64'hABCD, 0, 0, 0, 64'h0);
    tbl[7]  = mk(0, 4'hF, 64'h0,    4'hF, 64'h0,    1, 1, 4'h5, 64'hDEAD, 1, 4'h5, 64'hDEAD, 0, 0, 0, 64'h0);
    tbl[8]  = mk(0, 4'hF, 64'h0,    4'hF, 64'h0,    1, 1, 4'h5, 64'hDEAD, 0, 4'h0, 64'h0,    0, 1, 0, 64'h0);
    tbl[9]  = mk(0, 4'hF, 64'h0,    4'hF, 64'h0,    1, 0, 4'h5, 64'h0,    0, 4'h0, 64'h0,    0, 0, 0, 64'h0);
    tbl[10] = mk(1, 4'h7, 64'h77,   4'hF, 64'h0,    1, 0, 4'h5, 64'h0,    1, 4'h7, 64'h77,   0, 1, 1, 64'hDEAD);
    tbl[11] = mk(0, 4'hF, 64'h0,    4'hF, 64'h0,    1, 0, 4'hF, 64'h0,    0, 4'h0, 64'h0,    0, 0, 0, 64'h0);
    tbl[12] = mk(1, 4'h8, 64'h88,   4'h9, 64'h99,   1, 0, 4'hF, 64'h0,    1, 4'h8, 64'h88,   1, 1, 1, 64'h0);
    tbl[13] = mk(1, 4'h8, 64'h88,   4'h9, 64'h99,   0, 0, 4'h0, 64'h0,    1, 4'h9, 64'h99,   0, 0, 0, 64'h0);
    tbl[14] = mk(0, 4'hF, 64'h0,    4'hF, 64'h0,    1, 1, 4'hF, 64'h1111, 0, 4'h0, 64'h0,    0, 0, 0, 64'h0);
    tbl[15] = mk(0, 4'hF, 64'h0,    4'hF, 64'h0,    1, 1, 4'hF, 64'h1111, 0, 4'h0, 64'h0,    0, 1, 0, 64'h0);
    tbl[16] = mk(1, 4'hF, 64'h0,    4'hF, 64'h0,    0, 0, 4'h0, 64'h0,    0, 4'h0, 64'h0,    0, 0, 0, 64'h0);

    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    init_sequence("first");

    for (int i = 0; i < 17; i++) cyc(tbl[i], $sformatf("v%0d", i));
    chk("rf3", rf_mem[3], 64'h1234);
    chk("rf2", rf_mem[2], 64'hABCD);
    chk("rf4", rf_mem[4], 64'hABCD);
    chk("rf5", rf_mem[5], 64'hDEAD);

    // Starvation: core writes every cycle while debug waits.
    s = mk(1, 4'h1, 64'h11, 4'hF, 64'h0, 1, 1, 4'h9, 64'h99, 1, 4'h1, 64'h11, 0, 0, 0, 64'h0);
    for (int i = 0; i < 4; i++) cyc(s, $sformatf("st_lost%0d", i));
    s = mk(1, 4'h1, 64'h11, 4'hF, 64'h0, 1, 1, 4'h9, 64'h99, 1, 4'h9, 64'h99, 1, 0, 0, 64'h0);
    cyc(s, "st_grant");
    s = mk(1, 4'h1, 64'h11, 4'hF, 64'h0, 1, 1, 4'h9, 64'h99, 1, 4'h1, 64'h11, 0, 1, 0, 64'h0);
    cyc(s, "st_ack");
    s = mk(1, 4'h1, 64'h11, 4'hF, 64'h0, 0, 0, 4'h0, 64'h0, 1, 4'h1, 64'h11, 0, 0, 0, 64'h0);
    cyc(s, "st_drop");
    // Counter restarted from zero: four more lost cycles before a read gets in.
    s = mk(1, 4'h1, 64'h11, 4'hF, 64'h0, 1, 0, 4'h9, 64'h0, 1, 4'h1, 64'h11, 0, 0, 0, 64'h0);
    for (int i = 0; i < 4; i++) cyc(s, $sformatf("st2_lost%0d", i));
    s = mk(1, 4'h1, 64'h11, 4'hF, 64'h0, 1, 0, 4'h9, 64'h0, 0, 4'h0, 64'h0, 1, 0, 0, 64'h0);
    cyc(s, "st2_grant");
    s = mk(1, 4'h1, 64'h11, 4'hF, 64'h0, 1, 0, 4'h9, 64'h0, 1, 4'h1, 64'h11, 0, 1, 1, 64'h99);
    cyc(s, "st2_ack");

    // Reset while the M half of a popq is pending.
    s = mk(1, 4'h4, 64'h200, 4'h2, 64'h5555, 0, 0, 4'h0, 64'h0, 1, 4'h4, 64'h200, 1, 0, 0, 64'h0);
    cyc(s, "rst_e");
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_m_write", rf_mem[2], 64'hABCD);
    chk("rst_e_written", rf_mem[4], 64'h200);
    // Core and debug both request during INIT; neither may disturb the clear.
    wb_valid = 1'b1; dstE = 4'h7; valE = 64'hFFFF; dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 4'h7; dbg_wdata = 64'hFFFF;
    rst_n = 1'b1;
    init_sequence("second");
    chk("clr_r2", rf_mem[2], 64'h0);
    chk("clr_r4", rf_mem[4], 64'h0);
    chk("clr_r7", rf_mem[7], 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
Sequencing and arbitration controller for the single-write-port Y86 register file (15 x 64-bit, index 4'hF = "no register").
- After reset it clears all registers.
- It serializes dual writebacks (popq writes dstE and dstM) over two cycles and stalls the core for the extra cycle.
- It shares the write port and a spare read port with a debug/host requester, with a starvation guard.

Parameters:
NREG, 15, number of architectural registers cleared at init
DW, 64, data width
AW, 4, register address width; all-ones = none
STARVE_MAX, 4, consecutive lost debug arbitration cycles before debug preempts the core

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low
wb_valid_i  in  1  core writeback request this cycle
dstE_i  in  AW  E-write destination (F = none)
valE_i  in  DW  E-write data
dstM_i  in  AW  M-write destination (F = none)
valM_i  in  DW  M-write data
wb_stall_o  out  1  core must hold its writeback inputs and not advance
dbg_req_i  in  1  debug request, level, held until ack
dbg_we_i  in  1  1 = write, 0 = read
dbg_addr_i  in  AW  debug register index
dbg_wdata_i  in  DW  debug write data
dbg_ack_o  out  1  one-cycle completion pulse
dbg_rdata_o  out  DW  read data, valid while dbg_ack_o = 1
rf_we_o  out  1  register file write enable
rf_waddr_o  out  AW  write address
rf_wdata_o  out  DW  write data
rf_raddr_o  out  AW  spare read port address, equal to dbg_addr_i
rf_rdata_i  in  DW  spare read port data, combinational
init_done_o  out  1  register file cleared; controller operational

Behaviour:
- States: INIT, IDLE, WB_M, DBG_ACK. Async reset forces INIT with init counter = 0, starve counter = 0, latched dstM/valM cleared.
- While rst_n_i = 0: rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, dbg_ack_o = 0, dbg_rdata_o = 0, init_done_o = 0, wb_stall_o = 1.
- INIT:
  - Each cycle: rf_we_o = 1, rf_waddr_o = counter, rf_wdata_o = 0.
  - counter runs 0..NREG-1; on NREG-1 go to IDLE.
  - init_done_o is registered: it goes to 1 on the first IDLE cycle and stays 1 until reset.
  - wb_stall_o = 1 throughout. Debug is not granted and the starve counter is not incremented.
- Any write whose address is 4'hF is suppressed (rf_we_o = 0). It still counts as a completed write for handshakes.
- IDLE, no debug preemption, wb_valid_i = 1:
  - Only one of dstE_i / dstM_i is non-F: write it the same cycle; wb_stall_o = 0.
  - Both non-F: write dstE/valE this cycle with wb_stall_o = 1; latch dstM_i/valM_i; go to WB_M.
- WB_M:
  - Write latched dstM/valM; wb_stall_o = 0; return to IDLE.
  - If dstE = dstM, the M value is final (popq %rsp semantics).
  - Debug is not granted; the starve counter holds.
- Debug grant (IDLE only):
  - Granted when dbg_req_i = 1 and either wb_valid_i = 0, or starve counter = STARVE_MAX.
  - Preempting grant: wb_stall_o = 1 and no core write that cycle.
  - Grant cycle G: for a write, rf_we_o = 1, rf_waddr_o = dbg_addr_i, rf_wdata_o = dbg_wdata_i. For a read, rf_rdata_i is captured (0 if addr = F). Starve counter resets to 0. Go to DBG_ACK.
- DBG_ACK:
  - dbg_ack_o = 1 (registered) and dbg_rdata_o = captured value for exactly one cycle.
  - No new debug grant this cycle, even though dbg_req_i may still be high. Core writebacks are serviced normally.
  - Next state: IDLE, or WB_M if a dual writeback starts.
- Starve counter:
  - Increments (saturating at STARVE_MAX) in each IDLE cycle with dbg_req_i = 1 and no grant.
  - Cleared when dbg_req_i = 0.
- A preempted dual writeback is deferred intact: the core holds its inputs and it is serviced later.
- Reset mid-operation (any state): a pending WB_M write is dropped, ack is cleared, and INIT reruns fully.

Test Plan:
- Release reset -> rf_we_o = 1, addr 0..14, data 0 for 15 cycles. init_done_o = 1 on cycle 16. wb_stall_o = 1 through cycle 15.
- wb_valid, dstE = 3, valE = 0x1234, dstM = F -> same cycle write r3 = 0x1234; wb_stall_o = 0.
- popq: dstE = 4, valE = 0x108, dstM = 2, valM = 0xABCD -> cycle 1 r4 = 0x108 with stall = 1; cycle 2 r2 = 0xABCD with stall = 0. Repeat with dstE = dstM = 4 -> r4 ends 0xABCD.
- Idle debug write addr 5, data 0xDEAD -> write at G, ack at G+1 only. Debug read addr 5 -> ack with dbg_rdata_o = 0xDEAD. Read addr F -> 0.
- Continuous single wb_valid plus dbg_req held -> 4 lost cycles, 5th cycle debug granted with wb_stall_o = 1 and the core write deferred one cycle. Counter is 0 afterwards.
- Assert rst_n_i during WB_M (dstM = 2) -> no r2 write, outputs forced to reset values immediately, full INIT sequence repeats after release.
